// File: rtl/beat_scheduler_if.sv
// Pattern edit/load/readback bus: master issues taps, row loads and readback selects; slave owns the pattern memory.
interface beat_scheduler_if #(
  parameter int STEPS = 8
);
  logic             tap_valid;
  logic [2:0]       tap_voice;
  logic             ld_valid;
  logic             ld_ready;
  logic [2:0]       ld_voice;
  logic [STEPS-1:0] ld_pattern;
  logic [2:0]       rd_voice;
  logic [STEPS-1:0] rd_pattern;

  modport master (
    output tap_valid, tap_voice, ld_valid, ld_voice, ld_pattern, rd_voice,
    input  ld_ready, rd_pattern
  );

  modport slave (
    input  tap_valid, tap_voice, ld_valid, ld_voice, ld_pattern, rd_voice,
    output ld_ready, rd_pattern
  );
endinterface

// File: rtl/beat_scheduler.sv
// Drum step sequencer: step clock, stopped/count-in/running/paused transport, 5x8 pattern memory, trigger pulses.
// Latency: beat/bar/trig/state/step/rd_pattern registered, 1 cycle; ld_ready combinational.
// Backpressure: loads stall while a clear or tap owns the single write port.
module beat_scheduler #(
  parameter int VOICES   = 5,
  parameter int STEPS    = 8,
  parameter int PW       = 24,
  parameter int COUNT_IN = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [PW-1:0]            period,
  input  logic                     start,
  input  logic                     pause,
  input  logic                     stop,
  input  logic                     clear,
  beat_scheduler_if.slave          edit,
  output logic                     beat,
  output logic                     bar,
  output logic [VOICES-1:0]        trig,
  output logic [$clog2(STEPS)-1:0] step,
  output logic [1:0]               state
);
  localparam int SW = $clog2(STEPS);

  typedef enum logic [1:0] {
    ST_STOPPED  = 2'd0,
    ST_COUNT_IN = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_PAUSED   = 2'd3
  } state_t;

  state_t           st;
  logic [PW-1:0]    cnt;
  logic [3:0]       ci;
  logic [STEPS-1:0] pat [VOICES];

  logic [PW-1:0]     per_c;
  logic [SW-1:0]     step_inc;
  logic [VOICES-1:0] col_zero;
  logic [VOICES-1:0] col_inc;
  logic              adv;

  assign per_c    = (period < PW'(2)) ? PW'(2) : period;
  assign step_inc = step + SW'(1);
  assign state    = st;

  // Resume edge counts as a running cycle; the pause edge does not, so beat spacing stays per-step exact.
  assign adv = ((st == ST_RUNNING) && !pause) || ((st == ST_PAUSED) && start);

  assign edit.ld_ready = ~clear & ~edit.tap_valid;

  always_comb begin
    col_zero = '0;
    col_inc  = '0;
    for (int v = 0; v < VOICES; v++) begin
      col_zero[v] = pat[v][0];
      col_inc[v]  = pat[v][step_inc];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      st   <= ST_STOPPED;
      cnt  <= '0;
      ci   <= '0;
      step <= '0;
      beat <= 1'b0;
      bar  <= 1'b0;
      trig <= '0;
    end else begin
      beat <= 1'b0;
      bar  <= 1'b0;
      trig <= '0;
      if (stop) begin
        st   <= ST_STOPPED;
        step <= '0;
        cnt  <= '0;
        ci   <= '0;
      end else begin
        case (st)
          ST_STOPPED: begin
            if (start) begin
              st  <= ST_COUNT_IN;
              cnt <= per_c - 1'b1;
              ci  <= 4'(COUNT_IN);
            end
          end
          ST_COUNT_IN: begin
            if (cnt != '0) begin
              cnt <= cnt - 1'b1;
            end else begin
              cnt  <= per_c - 1'b1;
              beat <= 1'b1;
              // ci holds the count-in beats still to come before step 0.
              if (ci == '0) begin
                st   <= ST_RUNNING;
                step <= '0;
                bar  <= 1'b1;
                trig <= col_zero;
              end else begin
                ci <= ci - 1'b1;
              end
            end
          end
          ST_RUNNING: if (pause) st <= ST_PAUSED;
          ST_PAUSED:  if (start) st <= ST_RUNNING;
          default:    st <= ST_STOPPED;
        endcase
        if (adv) begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            cnt  <= per_c - 1'b1;
            beat <= 1'b1;
            step <= step_inc;
            trig <= col_inc;
            bar  <= (step_inc == '0);
          end
        end
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int v = 0; v < VOICES; v++) pat[v] <= '0;
      edit.rd_pattern <= '0;
    end else begin
      edit.rd_pattern <= (32'(edit.rd_voice) < VOICES) ? pat[edit.rd_voice] : '0;
      if (clear) begin
        for (int v = 0; v < VOICES; v++) pat[v] <= '0;
      end else if (edit.tap_valid) begin
        if (32'(edit.tap_voice) < VOICES) pat[edit.tap_voice][step] <= 1'b1;
      end else if (edit.ld_valid) begin
        // Out-of-range voice still completes the handshake; the row is simply dropped.
        if (32'(edit.ld_voice) < VOICES) pat[edit.ld_voice] <= edit.ld_pattern;
      end
    end
  end
endmodule
